// File: rtl/network_queue_dequeue_pkg.sv
// Shared constants and FSM encoding for the network queue dequeue block.
package nqd_pkg;

    localparam int QUEUE_NUM    = 8;
    localparam int ADDR_W       = 9;
    localparam int DATA_W       = 57;
    localparam int CNT_W        = 10;
    localparam int QID_W        = 3;
    localparam int NEXT_PTR_MSB = 56;
    localparam int NEXT_PTR_LSB = 48;
    localparam int DESC_W       = 48;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(512);

    typedef enum logic {
        IDLE_S = 1'b0,
        WAIT_S = 1'b1
    } state_e;

endpackage

// File: rtl/network_queue_dequeue_if.sv
// Enqueue, queue-RAM read and descriptor-out signals of the dequeue block.
interface network_queue_dequeue_if;
    import nqd_pkg::*;

    logic              i_enq_wr;
    logic [QID_W-1:0]  iv_enq_qid;
    logic [ADDR_W-1:0] iv_enq_addr;
    logic              i_desc_ready;
    logic [ADDR_W-1:0] ov_queue_raddr;
    logic              o_queue_rd;
    logic [DATA_W-1:0] iv_queue_rdata;
    logic              i_queue_rdata_valid;
    logic [DESC_W-1:0] ov_desc;
    logic [QID_W-1:0]  ov_desc_qid;
    logic              o_desc_wr;

    modport slave (
        input  i_enq_wr,
        input  iv_enq_qid,
        input  iv_enq_addr,
        input  i_desc_ready,
        output ov_queue_raddr,
        output o_queue_rd,
        input  iv_queue_rdata,
        input  i_queue_rdata_valid,
        output ov_desc,
        output ov_desc_qid,
        output o_desc_wr
    );

    modport master (
        output i_enq_wr,
        output iv_enq_qid,
        output iv_enq_addr,
        output i_desc_ready,
        input  ov_queue_raddr,
        input  o_queue_rd,
        output iv_queue_rdata,
        output i_queue_rdata_valid,
        input  ov_desc,
        input  ov_desc_qid,
        input  o_desc_wr
    );

endinterface

// File: rtl/network_queue_dequeue_prio_select.sv
// Strict-priority encoder: highest eligible queue index wins.
module nqd_prio_select
    import nqd_pkg::*;
(
    input  logic [QUEUE_NUM-1:0] elig_i,
    output logic                 vld_o,
    output logic [QID_W-1:0]     qid_o
);

    always_comb begin
        vld_o = 1'b0;
        qid_o = '0;
        for (int q = 0; q < QUEUE_NUM; q++) begin
            if (elig_i[q]) begin
                vld_o = 1'b1;
                qid_o = QID_W'(q);
            end
        end
    end

endmodule

// File: rtl/network_queue_dequeue.sv
// Read-side controller for the 8 linked-list priority queues.
// Optional NQD_STAT_EN adds per-queue 16-bit dequeue counters.
module network_queue_dequeue
    import nqd_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    network_queue_dequeue_if.slave bus,
    input  logic [QUEUE_NUM-1:0] iv_gate_state,
    output logic [QUEUE_NUM-1:0] ov_queue_empty,
    output logic                 o_enq_overflow
`ifdef NQD_STAT_EN
    ,
    input  logic [QID_W-1:0]     iv_stat_qid,
    output logic [15:0]          ov_stat_cnt
`endif
);

    state_e            state_q, state_d;
    logic [QID_W-1:0]  qid_q, qid_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              rd_q, rd_d;
    logic [DESC_W-1:0] desc_q, desc_d;
    logic [QID_W-1:0]  desc_qid_q, desc_qid_d;
    logic              desc_wr_q, desc_wr_d;
    logic              head_fixed_q, head_fixed_d;
    logic [QUEUE_NUM-1:0] empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] head_q [QUEUE_NUM];
    logic [ADDR_W-1:0] head_d [QUEUE_NUM];
    logic [CNT_W-1:0]  cnt_q [QUEUE_NUM];
    logic [CNT_W-1:0]  cnt_d [QUEUE_NUM];

    logic [QUEUE_NUM-1:0] elig;
    logic                 sel_vld;
    logic [QID_W-1:0]     sel_qid;
    logic                 complete;
    logic [CNT_W-1:0]     enq_eff;

    always_comb begin
        elig = '0;
        for (int q = 0; q < QUEUE_NUM; q++) begin
            elig[q] = (cnt_q[q] != '0)
                    && iv_gate_state[q]
                    && bus.i_desc_ready;
        end
    end

    nqd_prio_select u_sel (
        .elig_i (elig),
        .vld_o  (sel_vld),
        .qid_o  (sel_qid)
    );

    always_comb begin
        state_d      = state_q;
        qid_d        = qid_q;
        raddr_d      = raddr_q;
        rd_d         = 1'b0;
        desc_d       = desc_q;
        desc_qid_d   = desc_qid_q;
        desc_wr_d    = 1'b0;
        head_fixed_d = head_fixed_q;
        ovf_d        = 1'b0;
        head_d       = head_q;
        cnt_d        = cnt_q;
        complete     = 1'b0;
        enq_eff      = '0;
        empty_d      = '0;

        unique case (state_q)
            IDLE_S: begin
                if (sel_vld) begin
                    qid_d          = sel_qid;
                    raddr_d        = head_q[sel_qid];
                    rd_d           = 1'b1;
                    cnt_d[sel_qid] = cnt_q[sel_qid] - CNT_W'(1);
                    head_fixed_d   = 1'b0;
                    state_d        = WAIT_S;
                end
            end
            WAIT_S: begin
                if (bus.i_queue_rdata_valid) begin
                    complete   = 1'b1;
                    desc_d     = bus.iv_queue_rdata[DESC_W-1:0];
                    desc_qid_d = qid_q;
                    desc_wr_d  = 1'b1;
                    state_d    = IDLE_S;
                end
            end
        endcase

        // Overflow uses the post-issue count; head load uses the
        // pre-issue count, so a same-cycle issue never reloads head.
        if (bus.i_enq_wr) begin
            enq_eff = cnt_d[bus.iv_enq_qid];
            if (enq_eff == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d[bus.iv_enq_qid] = enq_eff + CNT_W'(1);
                if (cnt_q[bus.iv_enq_qid] == '0) begin
                    head_d[bus.iv_enq_qid] = bus.iv_enq_addr;
                    if (state_q == WAIT_S && qid_q == bus.iv_enq_qid) begin
                        head_fixed_d = 1'b1;
                    end
                end
            end
        end

        if (complete && cnt_d[qid_q] != '0 && !head_fixed_d) begin
            head_d[qid_q] =
                bus.iv_queue_rdata[NEXT_PTR_MSB:NEXT_PTR_LSB];
        end

        for (int q = 0; q < QUEUE_NUM; q++) begin
            empty_d[q] = (cnt_d[q] == '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE_S;
            qid_q        <= '0;
            raddr_q      <= '0;
            rd_q         <= 1'b0;
            desc_q       <= '0;
            desc_qid_q   <= '0;
            desc_wr_q    <= 1'b0;
            head_fixed_q <= 1'b0;
            empty_q      <= '1;
            ovf_q        <= 1'b0;
            for (int q = 0; q < QUEUE_NUM; q++) begin
                head_q[q] <= '0;
                cnt_q[q]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            qid_q        <= qid_d;
            raddr_q      <= raddr_d;
            rd_q         <= rd_d;
            desc_q       <= desc_d;
            desc_qid_q   <= desc_qid_d;
            desc_wr_q    <= desc_wr_d;
            head_fixed_q <= head_fixed_d;
            empty_q      <= empty_d;
            ovf_q        <= ovf_d;
            head_q       <= head_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.ov_queue_raddr = raddr_q;
    assign bus.o_queue_rd     = rd_q;
    assign bus.ov_desc        = desc_q;
    assign bus.ov_desc_qid    = desc_qid_q;
    assign bus.o_desc_wr      = desc_wr_q;
    assign ov_queue_empty     = empty_q;
    assign o_enq_overflow     = ovf_q;

`ifdef NQD_STAT_EN
    logic [15:0] stat_q [QUEUE_NUM];
    logic [15:0] stat_rd_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int q = 0; q < QUEUE_NUM; q++) begin
                stat_q[q] <= '0;
            end
            stat_rd_q <= '0;
        end else begin
            if (desc_wr_q) begin
                stat_q[desc_qid_q] <= stat_q[desc_qid_q] + 16'd1;
            end
            stat_rd_q <= stat_q[iv_stat_qid];
        end
    end

    assign ov_stat_cnt = stat_rd_q;
`endif

endmodule

// File: tb/tb_network_queue_dequeue.sv
// Scoreboard bench for network_queue_dequeue with a 2-cycle queue RAM model.
module tb_network_queue_dequeue;
    import nqd_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    network_queue_dequeue_if bus();
    logic [7:0] gate;
    logic [7:0] empty;
    logic       ovf;
`ifdef NQD_STAT_EN
    logic [2:0]  stat_qid;
    logic [15:0] stat_cnt;
`endif

    network_queue_dequeue dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .bus            (bus),
        .iv_gate_state  (gate),
        .ov_queue_empty (empty),
        .o_enq_overflow (ovf)
`ifdef NQD_STAT_EN
        ,
        .iv_stat_qid    (stat_qid),
        .ov_stat_cnt    (stat_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    logic [56:0] ram [512];
    logic [8:0]  exp_raddr [$];
    logic [50:0] exp_desc [$];
    int          pend_cnt = 0;
    logic [8:0]  pend_addr = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Queue RAM model: read data valid two cycles after the read strobe.
    always @(negedge clk) begin
        bus.i_queue_rdata_valid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.i_queue_rdata_valid = 1'b1;
                bus.iv_queue_rdata = ram[pend_addr];
            end
        end
        if (bus.o_queue_rd) begin
            pend_cnt = 2;
            pend_addr = bus.ov_queue_raddr;
        end
    end

    // Monitor: pop and compare on every read strobe and descriptor strobe.
    always @(negedge clk) begin
        if (bus.o_queue_rd) begin
            if (exp_raddr.size() == 0) begin
                chk("unexpected_rd", {55'd0, bus.ov_queue_raddr}, 64'hFFFF);
            end else begin
                chk("raddr", {55'd0, bus.ov_queue_raddr},
                    {55'd0, exp_raddr.pop_front()});
            end
        end
        if (bus.o_desc_wr) begin
            if (exp_desc.size() == 0) begin
                chk("unexpected_desc", {13'd0, bus.ov_desc_qid, bus.ov_desc},
                    64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("desc", {13'd0, bus.ov_desc_qid, bus.ov_desc},
                    {13'd0, exp_desc.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(int q, int addr);
        bus.i_enq_wr = 1'b1;
        bus.iv_enq_qid = 3'(q);
        bus.iv_enq_addr = 9'(addr);
        tick();
        bus.i_enq_wr = 1'b0;
    endtask

    task automatic expect_rd(int q, int addr, logic [47:0] d);
        exp_raddr.push_back(9'(addr));
        exp_desc.push_back({3'(q), d});
    endtask

    task automatic drain(int max_cyc);
        int n = 0;
        while ((exp_raddr.size() != 0 || exp_desc.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain_timeout", {63'd0, n >= max_cyc}, 64'd0);
        repeat (6) tick();
    endtask

    initial begin
        bus.i_enq_wr = 1'b0;
        bus.iv_enq_qid = '0;
        bus.iv_enq_addr = '0;
        bus.i_desc_ready = 1'b1;
        bus.iv_queue_rdata = '0;
        bus.i_queue_rdata_valid = 1'b0;
        gate = 8'hFF;
`ifdef NQD_STAT_EN
        stat_qid = 3'd0;
`endif
        for (int i = 0; i < 512; i++) ram[i] = '0;

        #12;
        chk("rst_rd", {63'd0, bus.o_queue_rd}, 64'd0);
        chk("rst_raddr", {55'd0, bus.ov_queue_raddr}, 64'd0);
        chk("rst_desc_wr", {63'd0, bus.o_desc_wr}, 64'd0);
        chk("rst_desc", {16'd0, bus.ov_desc}, 64'd0);
        chk("rst_empty", {56'd0, empty}, 64'hFF);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: single entry on q3
        ram[5] = {9'd0, 48'hA5};
        expect_rd(3, 5, 48'hA5);
        enq(3, 5);
        drain(100);
        chk("t1_empty3", {63'd0, empty[3]}, 64'd1);
        chk("t1_empty_all", {56'd0, empty}, 64'hFF);

        // ready low blocks service
        ram[60] = {9'd0, 48'hF60};
        bus.i_desc_ready = 1'b0;
        enq(7, 60);
        repeat (4) tick();
        chk("rdy_empty7", {63'd0, empty[7]}, 64'd0);
        expect_rd(7, 60, 48'hF60);
        bus.i_desc_ready = 1'b1;
        drain(100);

        // 2: linked pair on q2, second enqueue coincides with issue
        ram[10] = {9'd11, 48'hB10};
        ram[11] = {9'd0, 48'hB11};
        expect_rd(2, 10, 48'hB10);
        expect_rd(2, 11, 48'hB11);
        enq(2, 10);
        enq(2, 11);
        drain(100);
        chk("t2_empty2", {63'd0, empty[2]}, 64'd1);

        // 3: gating and strict priority
        gate = 8'h00;
        ram[30] = {9'd31, 48'hC30};
        ram[31] = {9'd0, 48'hC31};
        ram[40] = {9'd0, 48'hC40};
        enq(1, 30);
        enq(1, 31);
        enq(6, 40);
        repeat (3) tick();
        chk("t3_gated_empty", {56'd0, empty}, 64'hBD);
        expect_rd(1, 30, 48'hC30);
        gate = 8'h02;
        tick();
        gate = 8'h00;
        drain(100);
        expect_rd(6, 40, 48'hC40);
        expect_rd(1, 31, 48'hC31);
        gate = 8'hFF;
        drain(100);

        // 4: enqueue into q4 while its last entry is in flight
        ram[15] = {9'd0, 48'hD15};
        ram[20] = {9'd0, 48'hD20};
        expect_rd(4, 15, 48'hD15);
        expect_rd(4, 20, 48'hD20);
        enq(4, 15);
        tick();
        enq(4, 20);
        drain(100);
        chk("t4_empty4", {63'd0, empty[4]}, 64'd1);

        // 5: fill q0 to 512, overflow on 513th, then drain all
        gate = 8'h00;
        for (int i = 0; i < 512; i++) ram[i] = {9'(i + 1), 48'hE000 + 48'(i)};
        for (int i = 0; i < 512; i++) enq(0, i);
        chk("t5_ovf_512", {63'd0, ovf}, 64'd0);
        chk("t5_empty0", {63'd0, empty[0]}, 64'd0);
        enq(0, 0);
        chk("t5_ovf_pulse", {63'd0, ovf}, 64'd1);
        tick();
        chk("t5_ovf_clear", {63'd0, ovf}, 64'd0);
        for (int i = 0; i < 512; i++) expect_rd(0, i, 48'hE000 + 48'(i));
        gate = 8'hFF;
        drain(4000);
        chk("t5_drained", {56'd0, empty}, 64'hFF);

        // 5b: reset during WAIT, late valid must be ignored
        ram[100] = {9'd0, 48'hE100};
        exp_raddr.push_back(9'd100);
        enq(0, 100);
        tick();
        #5;
        rst_n = 1'b0;
        #2;
        chk("t5_rst_empty", {56'd0, empty}, 64'hFF);
        chk("t5_rst_rd", {63'd0, bus.o_queue_rd}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_no_desc", {63'd0, bus.o_desc_wr}, 64'd0);
        end
        chk("t5_exp_rd_seen", 64'(exp_raddr.size()), 64'd0);

`ifdef NQD_STAT_EN
        // 6: dequeue statistics
        ram[50] = {9'd51, 48'h5A};
        ram[51] = {9'd52, 48'h5B};
        ram[52] = {9'd0, 48'h5C};
        expect_rd(5, 50, 48'h5A);
        expect_rd(5, 51, 48'h5B);
        expect_rd(5, 52, 48'h5C);
        enq(5, 50);
        enq(5, 51);
        enq(5, 52);
        drain(100);
        stat_qid = 3'd5;
        tick();
        chk("t6_stat5", {48'd0, stat_cnt}, 64'd3);
        stat_qid = 3'd0;
        tick();
        chk("t6_stat0", {48'd0, stat_cnt}, 64'd0);
`endif

        chk("end_rd_queue", 64'(exp_raddr.size()), 64'd0);
        chk("end_desc_queue", 64'(exp_desc.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
